// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and sizes for the calculator result path
package calc_pkg;

    localparam int CALC_WIDTH = 8;
    localparam int BCD_DIGITS = 3;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector: adds 3 to any digit of 5 or more
module bcd_add3
    import calc_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative binary to BCD converter with sign and blanking flags
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output bcd_digit_t       bcd_hund,
    output bcd_digit_t       bcd_tens,
    output bcd_digit_t       bcd_ones,
    output logic             neg,
    output logic             blank_hund,
    output logic             blank_tens
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sign_q, sign_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    bcd_digit_t       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic             neg_q, neg_d;
    logic             blank_hund_q, blank_hund_d;
    logic             blank_tens_q, blank_tens_d;
    logic             accept;
    logic             last_shift;
    logic [BW+WIDTH-1:0] work;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CW'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they come straight off flops.
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_comb begin
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        mag_d        = mag_q;
        sign_d       = sign_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        neg_d        = neg_q;
        blank_hund_d = blank_hund_q;
        blank_tens_d = blank_tens_q;
        work         = {bcd_adj, mag_q} << 1;
        if (accept) begin
            sign_d = is_signed & bin[WIDTH-1];
            mag_d  = sign_d ? (~bin + WIDTH'(1)) : bin;
            bcd_d  = '0;
            cnt_d  = CW'(WIDTH);
        end else if (state_q == ST_SHIFT) begin
            bcd_d = work[BW+WIDTH-1:WIDTH];
            mag_d = work[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (last_shift) begin
                hund_d       = bcd_d[8 +: 4];
                tens_d       = bcd_d[4 +: 4];
                ones_d       = bcd_d[0 +: 4];
                neg_d        = sign_q;
                blank_hund_d = (hund_d == 4'd0);
                blank_tens_d = (hund_d == 4'd0) && (tens_d == 4'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bcd_q        <= '0;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            neg_q        <= 1'b0;
            blank_hund_q <= 1'b1;
            blank_tens_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            mag_q        <= mag_d;
            sign_q       <= sign_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            neg_q        <= neg_d;
            blank_hund_q <= blank_hund_d;
            blank_tens_q <= blank_tens_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bcd_hund   = hund_q;
    assign bcd_tens   = tens_q;
    assign bcd_ones   = ones_q;
    assign neg        = neg_q;
    assign blank_hund = blank_hund_q;
    assign blank_tens = blank_tens_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       n;
        logic       bh;
        logic       bt;
    } res_t;

    typedef struct {
        logic [7:0] b;
        logic       s;
        res_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       is_signed = 1'b0;
    logic       busy, done, neg, blank_hund, blank_tens;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;

    int   total = 0;
    int   bad = 0;
    res_t exp_q[$];
    res_t mon_exp;
    vec_t vecs[11];

    bin2bcd_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bin        (bin),
        .is_signed  (is_signed),
        .busy       (busy),
        .done       (done),
        .bcd_hund   (bcd_hund),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .neg        (neg),
        .blank_hund (blank_hund),
        .blank_tens (blank_tens)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input int h, input int t, input int o,
                                input logic n, input logic bh, input logic bt);
        res_t r;
        r.h = 4'(h); r.t = 4'(t); r.o = 4'(o);
        r.n = n; r.bh = bh; r.bt = bt;
        return r;
    endfunction

    function automatic res_t actual();
        return {bcd_hund, bcd_tens, bcd_ones, neg, blank_hund, blank_tens};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result 0x%0h with empty queue", actual());
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'(actual()), 32'(mon_exp));
            end
        end
    end

    task automatic check_reset_vals(input string nm);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_outs"}, 32'(actual()), 32'(mk(0, 0, 0, 1'b0, 1'b1, 1'b1)));
    endtask

    task automatic run_conv(input logic [7:0] b, input logic s, input res_t e, input string nm);
        int  busy_cnt;
        int  lat;
        bit  seen;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bin = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; lat = -1; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat = i;
                check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            end else if (busy) begin
                busy_cnt++;
            end
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_latency"}, 32'(lat), 32'd8);
        check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        int  t1, t2, dcnt;
        bit  seen;

        vecs[0]  = '{8'd255, 1'b0, mk(2, 5, 5, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{8'h80,  1'b1, mk(1, 2, 8, 1'b1, 1'b0, 1'b0)};
        vecs[2]  = '{8'hFF,  1'b1, mk(0, 0, 1, 1'b1, 1'b1, 1'b1)};
        vecs[3]  = '{8'd0,   1'b0, mk(0, 0, 0, 1'b0, 1'b1, 1'b1)};
        vecs[4]  = '{8'd9,   1'b0, mk(0, 0, 9, 1'b0, 1'b1, 1'b1)};
        vecs[5]  = '{8'd100, 1'b0, mk(1, 0, 0, 1'b0, 1'b0, 1'b0)};
        vecs[6]  = '{8'h80,  1'b0, mk(1, 2, 8, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{8'h7F,  1'b1, mk(1, 2, 7, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{8'h9C,  1'b1, mk(1, 0, 0, 1'b1, 1'b0, 1'b0)};
        vecs[9]  = '{8'd50,  1'b0, mk(0, 5, 0, 1'b0, 1'b1, 1'b0)};
        vecs[10] = '{8'd199, 1'b0, mk(1, 9, 9, 1'b0, 1'b0, 1'b0)};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        foreach (vecs[i]) run_conv(vecs[i].b, vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));

        // Back-to-back: start held high, second operand offered in the DONE cycle.
        exp_q.push_back(mk(0, 4, 2, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 0, 7, 1'b0, 1'b1, 1'b1));
        @(posedge clk); #1;
        bin = 8'd42; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        seen = 1'b0; t1 = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; t1 = i; end
        end
        check("b2b_first_latency", 32'(t1), 32'd8);
        bin = 8'd7;
        seen = 1'b0; t2 = -1;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; t2 = j + 1; start = 1'b0; end
        end
        start = 1'b0;
        check("b2b_second_spacing", 32'(t2), 32'd9);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("b2b_no_extra_done", 32'(dcnt), 32'd0);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort: reset during the fourth SHIFT cycle.
        @(posedge clk); #1;
        bin = 8'd200; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check_reset_vals("abort");

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; bin = 8'd5;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_prio_busy", 32'(busy), 32'd0);

        run_conv(8'd57, 1'b0, mk(0, 5, 7, 1'b0, 1'b1, 1'b0), "after_abort");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter for the 8-bit four-function calculator result path. It sits directly upstream of the per-digit seven-segment decoders. It accepts an 8-bit result, optionally interpreted as two's complement, and runs an iterative shift-add-3 (double-dabble) conversion. It presents three registered BCD digits plus sign and leading-zero flags, each digit driving one 4-bit decoder input.

## Interface

Reset is synchronous and active-high. The block uses one clock.

Parameters:
- `WIDTH`, default 8: binary input width. It is also the number of shift iterations.
- `DIGITS`, default 3: number of BCD digits. It must satisfy 10^DIGITS > 2^WIDTH. The RTL is verified only at the defaults.

Ports:
- `clk`, in, 1: the single clock. All state is updated on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a conversion. It is sampled only in IDLE and DONE.
- `bin`, in, WIDTH: value to convert. It is captured in the cycle `start` is accepted.
- `is_signed`, in, 1: when 1, `bin` is treated as two's complement. It is captured with `bin`.
- `busy`, out, 1: high while the conversion is iterating.
- `done`, out, 1: one-cycle pulse. Outputs are updated in the same cycle.
- `bcd_hund`, out, 4: hundreds digit.
- `bcd_tens`, out, 4: tens digit.
- `bcd_ones`, out, 4: ones digit.
- `neg`, out, 1: the result was negative.
- `blank_hund`, out, 1: hundreds digit is a leading zero.
- `blank_tens`, out, 1: hundreds and tens are both leading zeros.

## Operation

States: IDLE, SHIFT, DONE.

- **IDLE**
  - If `start`=1, capture the magnitude and the sign.
  - Magnitude is `-bin` when `is_signed` and `bin[WIDTH-1]` are both 1; otherwise it is `bin`.
  - Sign is `is_signed & bin[WIDTH-1]`.
  - Clear the working BCD register, load the iteration counter with WIDTH, and go to SHIFT.
- **SHIFT**, one iteration per cycle:
  - Each working digit that is ≥5 has 3 added to it.
  - Then {BCD, magnitude} shifts left by one.
  - The counter decrements. When it reaches 0, the final shifted value loads the output registers and the state goes to DONE.
- **DONE**, one cycle:
  - `done`=1.
  - If `start`=1, a new conversion is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.

Arithmetic and width rules:
- Magnitude is WIDTH bits and unsigned. Signed −128 (8'h80) negates to 128, which is representable and correct.
- Working BCD is 4·DIGITS bits. Add-3 is applied per nibble with no carry between nibbles.

Output rules:
- `blank_hund` = (hund==0).
- `blank_tens` = (hund==0)&&(tens==0).
- The ones digit is never blanked, so zero displays as "0".
- Digit, sign and blank outputs change only when the output registers load. They hold the previous result through the next conversion.
- `start` while in SHIFT is ignored. It is neither queued nor an error.

## Timing

- Start accepted at edge E0.
- `busy`=1 for exactly WIDTH cycles, from after E0 through after E0+WIDTH−1.
- Outputs load at edge E0+WIDTH (E0+8 at defaults). `done`=1 for the single cycle following that edge. `busy`=0 in that cycle.
- Latency from the start edge to valid outputs is WIDTH cycles. With back-to-back starts taken in DONE, throughput is one conversion per WIDTH+1 cycles.
- Reset values: `busy`=0, `done`=0, all digits 0, `neg`=0, `blank_hund`=1, `blank_tens`=1, state IDLE.
- Reset asserted mid-SHIFT aborts the conversion. No `done` is produced and outputs take their reset values. Reset has priority over `start` in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure

- A shared package `calc_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - `CALC_WIDTH`=8 and `BCD_DIGITS`=3;
  - a `bcd_digit_t` 4-bit typedef, reused by the seven-segment decoder inputs.
- Sub-module `bcd_add3`: a combinational 4-bit ≥5 → +3 corrector, instantiated DIGITS times via generate.
- The FSM, counter and shift register live in `bin2bcd_seq`.

## Test plan

- Unsigned 8'd255, `is_signed`=0, start pulse → `done` 8 cycles after the start edge. Outputs 2/5/5, `neg`=0, both blanks 0. `busy` high for exactly 8 cycles.
- Signed 8'h80 → 1/2/8, `neg`=1. Signed 8'hFF → 0/0/1, `neg`=1, `blank_hund`=1, `blank_tens`=1.
- 8'd0 → 0/0/0 with both blanks 1. 8'd9 → 0/0/9. 8'd100 → 1/0/0 with both blanks 0.
- Start 8'd42 and hold `start` high throughout. Second `bin`=8'd7 is presented in the DONE cycle → back-to-back conversion, first `done` shows 0/4/2, second `done` 9 cycles later shows 0/0/7. `start` pulses during SHIFT produce no extra `done`.
- Start 8'd200, assert `reset` at the 4th SHIFT cycle → no `done`, outputs at reset values. A fresh start of 8'd57 → 0/5/7.
